// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul result drain path.
// Holds the drain state encoding, counter width and signed clip helper.
package matmul_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    localparam int SAT_CNT_W = 16;
    localparam int CLIP_W    = 64;

    // Clamp v (sign-extended from in_w bits) into the signed out_w range.
    function automatic logic signed [CLIP_W-1:0] sat_clip(
        input logic signed [CLIP_W-1:0] v,
        input int                       in_w,
        input int                       out_w
    );
        logic signed [CLIP_W-1:0] hi;
        logic signed [CLIP_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (out_w >= in_w) return v;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/signed_saturate.sv
// One-element clip stage: IN_W signed in, OUT_W out, with a clipped flag.
// SAT=0 selects plain truncation and never flags a clip.
module signed_saturate
    import matmul_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SAT   = 1
) (
    input  logic [IN_W-1:0]  d,
    output logic [OUT_W-1:0] q,
    output logic             clipped
);

    logic signed [CLIP_W-1:0] wide;
    logic signed [CLIP_W-1:0] clip_v;

    always_comb begin
        wide   = CLIP_W'($signed(d));
        clip_v = sat_clip(wide, IN_W, OUT_W);
        if (SAT != 0) begin
            q       = clip_v[OUT_W-1:0];
            clipped = (clip_v != wide);
        end else begin
            q       = d[OUT_W-1:0];
            clipped = 1'b0;
        end
    end

endmodule

// File: rtl/matmul_result_drain.sv
// Buffers one M x N result matrix and streams it out a row per beat.
// A new matrix may be accepted on the last-row beat, so no bubble occurs.
module matmul_result_drain
    import matmul_pkg::*;
#(
    parameter int  M     = 4,
    parameter int  N     = 4,
    parameter int  P     = 8,
    parameter int  OUT_W = 32,
    parameter int  SAT   = 1,
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M*N*4*P-1:0]   in_d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*OUT_W-1:0]   out_row,
    output logic [IDX_W-1:0]     out_row_idx,
    output logic                 out_last,
    output logic [SAT_CNT_W-1:0] sat_count,
    input  logic                 sat_clr
);

    localparam int EW    = 4 * P;
    localparam int ROW_W = N * EW;

    localparam logic [0:0] S_IDLE  = ST_IDLE;
    localparam logic [0:0] S_DRAIN = ST_DRAIN;

    logic [0:0]           state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [M*ROW_W-1:0]   mat_q;
    logic [ROW_W-1:0]     row;
    logic [N-1:0]         clip_v;
    logic [SAT_CNT_W-1:0] cnt_q;
    logic                 in_hs;
    logic                 out_hs;

    assign out_valid   = (state_q == S_DRAIN);
    assign out_last    = out_valid && (ptr_q == IDX_W'(M - 1));
    assign in_ready    = rst_n &&
                         ((state_q == S_IDLE) || (out_last && out_ready));
    assign in_hs       = in_valid && in_ready;
    assign out_hs      = out_valid && out_ready;
    assign out_row_idx = ptr_q;
    assign sat_count   = cnt_q;

    always_comb begin
        row = mat_q[int'(ptr_q)*ROW_W +: ROW_W];
    end

    for (genvar c = 0; c < N; c++) begin : g_sat
        signed_saturate #(
            .IN_W  (EW),
            .OUT_W (OUT_W),
            .SAT   (SAT)
        ) u_sat (
            .d       (row[c*EW +: EW]),
            .q       (out_row[c*OUT_W +: OUT_W]),
            .clipped (clip_v[c])
        );
    end

    // Matrix storage carries no reset; out_row is don't-care in IDLE.
    always_ff @(posedge clk) begin
        if (in_hs) mat_q <= in_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_hs) begin
                        state_q <= S_DRAIN;
                        ptr_q   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_hs) begin
                        if (out_last) begin
                            ptr_q   <= '0;
                            state_q <= in_hs ? S_DRAIN : S_IDLE;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (sat_clr) begin
            cnt_q <= '0;
        end else if (out_hs && (|clip_v) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Self-checking bench: directed scenarios plus random traffic against a
// row-queue reference model; a SAT=0 twin checks truncation behaviour.
module tb_matmul_result_drain;

    localparam int M = 2;
    localparam int N = 2;
    localparam int P = 8;
    localparam int W = 16;

    typedef struct {
        int e [N];
        int idx;
        bit last;
    } row_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic             sat_clr;
    logic [M*N*32-1:0] in_d;

    logic             in_ready, out_valid, out_last;
    logic [N*W-1:0]   out_row;
    logic [0:0]       out_row_idx;
    logic [15:0]      sat_count;

    logic             in_ready0, out_valid0, out_last0;
    logic [N*W-1:0]   out_row0;
    logic [0:0]       out_row_idx0;
    logic [15:0]      sat_count0;

    matmul_result_drain #(
        .M(M), .N(N), .P(P), .OUT_W(W), .SAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_row_idx(out_row_idx),
        .out_last(out_last), .sat_count(sat_count), .sat_clr(sat_clr)
    );

    matmul_result_drain #(
        .M(M), .N(N), .P(P), .OUT_W(W), .SAT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0), .in_d(in_d),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_row(out_row0), .out_row_idx(out_row_idx0),
        .out_last(out_last0), .sat_count(sat_count0), .sat_clr(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk;
    int   n_fail;
    row_t q[$];
    int   cur [M][N];
    int   cnt_m;
    bit   acc;

    task automatic check(input string tag,
                         input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clip16(input int v, input bit sat);
        logic [15:0] t;
        if (sat) begin
            if (v > 32767) return 32767;
            if (v < -32768) return -32768;
            return v;
        end
        t = v[15:0];
        return int'($signed(t));
    endfunction

    task automatic set_mat(input int a, input int b,
                           input int c, input int d);
        cur[0][0] = a; cur[0][1] = b;
        cur[1][0] = c; cur[1][1] = d;
        for (int r = 0; r < M; r++)
            for (int k = 0; k < N; k++)
                in_d[(r*N+k)*32 +: 32] = cur[r][k];
    endtask

    function automatic int rnd_val();
        int sel;
        sel = int'($urandom % 4);
        if (sel == 0) return int'($urandom_range(32768, 200000));
        if (sel == 1) return -int'($urandom_range(32769, 200000));
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    task automatic step();
        bit exp_ir, ohs, ihs, clip;
        row_t nr;
        @(negedge clk);
        exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready);
        check("out_valid", out_valid, q.size() > 0);
        check("out_valid_s0", out_valid0, q.size() > 0);
        check("in_ready", in_ready, exp_ir);
        check("in_ready_s0", in_ready0, exp_ir);
        check("sat_count", sat_count, cnt_m);
        check("sat_count_s0", sat_count0, 0);
        if (q.size() > 0) begin
            check("row_idx", out_row_idx, q[0].idx);
            check("row_last", out_last, q[0].last);
            check("row_last_s0", out_last0, q[0].last);
            for (int c = 0; c < N; c++) begin
                check("row_elem", $signed(out_row[c*W +: W]),
                      clip16(q[0].e[c], 1'b1));
                check("row_elem_s0", $signed(out_row0[c*W +: W]),
                      clip16(q[0].e[c], 1'b0));
            end
        end
        ohs  = (q.size() > 0) && out_ready;
        ihs  = in_valid && exp_ir;
        clip = 1'b0;
        if (ohs)
            for (int c = 0; c < N; c++)
                if (q[0].e[c] > 32767 || q[0].e[c] < -32768) clip = 1'b1;
        if (sat_clr) cnt_m = 0;
        else if (ohs && clip && cnt_m != 65535) cnt_m++;
        if (ohs) void'(q.pop_front());
        if (ihs) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) nr.e[c] = cur[r][c];
                nr.idx  = r;
                nr.last = (r == M - 1);
                q.push_back(nr);
            end
        end
        acc = ihs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cnt_m = 0; acc = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        set_mat(0, 0, 0, 0);

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic drain
        set_mat(1, 2, 3, 4); in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // back-pressure
        set_mat(1, 2, 3, 4); in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (3) step();

        // clipping
        set_mat(40000, -40000, 0, 0); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("clip_count", sat_count, 1);

        // back-to-back
        set_mat(1, 2, 3, 4); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        set_mat(5, 6, 7, 8); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // reset mid-drain
        set_mat(9, 10, 11, 12); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_sat_count", sat_count, 0);
        check("mid_rst_out_last", out_last, 0);
        q.delete();
        cnt_m = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) step();

        // clear collides with a clipped-row handshake
        set_mat(40000, 1, -40000, 3); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        step();
        check("clr_collision", sat_count, 0);

        // random traffic
        acc = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (!in_valid || acc) begin
                in_valid = 1'($urandom % 2);
                set_mat(rnd_val(), rnd_val(), rnd_val(), rnd_val());
            end
            out_ready = (($urandom % 4) != 0);
            sat_clr   = (($urandom % 32) == 0);
            step();
        end

        // counter saturation
        sat_clr = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        set_mat(40000, 40000, -40000, -40000);
        repeat (65600) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("sat_hold", sat_count, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
